mem_arbiter: RTL and testbench

//  Shares the single-ported RAM between the instruction fetch path and the data path.

---
 rtl/cpu_types_pkg.sv | 6 +
 rtl/llsc_link.sv | 31 +++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake state, word type and memory arbiter FSM states.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [1:0] {IDLE, IGNT, DGNT} arb_state_t;
endpackage

// File: rtl/llsc_link.sv
// Load-linked reservation: one valid bit plus the linked word address.
module llsc_link
    import cpu_types_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_set,
    input  logic  i_clr,
    input  word_t i_addr,
    output logic  o_hit,
    output logic  o_match
);
    logic  r_valid;
    word_t r_addr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
        end else if (i_set) begin
            r_valid <= 1'b1;
            r_addr  <= i_addr;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end
    end

    // A plain store to the linked address kills the link even if it is already invalid.
    assign o_hit   = (r_addr == i_addr);
    assign o_match = r_valid && o_hit;
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported RAM between instruction fetch and data access,
// with data priority bounded by IMAX and an LL/SC reservation.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int    IMAX   = 4,
    parameter word_t ERRVAL = 32'hBAD1BAD1
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  logic      datomic,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      memerr
);
    localparam int CW = $clog2(IMAX + 1);
    localparam logic [CW-1:0] DMAX = CW'(IMAX);

    arb_state_t    r_state, w_next;
    logic [CW-1:0] r_dcount;
    logic          r_memerr;
    logic          w_dpend, w_ram_done, w_err;
    logic          w_i_done, w_d_done, w_d_ram_done, w_sc_fail;
    logic          w_link_set, w_link_clr, w_hit, w_match;

    assign w_dpend    = dREN | dWEN;
    assign w_err      = (ramstate == ERROR);
    assign w_ram_done = (ramstate == ACCESS) | w_err;
    assign memerr     = r_memerr;

    always_comb begin
        w_next       = r_state;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        iwait        = 1'b1;
        dwait        = 1'b1;
        iload        = '0;
        dload        = '0;
        w_i_done     = 1'b0;
        w_d_done     = 1'b0;
        w_d_ram_done = 1'b0;
        w_sc_fail    = dWEN & datomic & ~w_match;
        case (r_state)
            IDLE: begin
                if (w_dpend && !(iREN && r_dcount == DMAX)) w_next = DGNT;
                else if (iREN)                              w_next = IGNT;
            end
            IGNT: begin
                if (!iREN) begin
                    w_next = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (w_ram_done) begin
                        iwait    = 1'b0;
                        iload    = w_err ? ERRVAL : ramload;
                        w_i_done = 1'b1;
                        w_next   = IDLE;
                    end
                end
            end
            DGNT: begin
                if (!w_dpend) begin
                    w_next = IDLE;
                end else if (w_sc_fail) begin
                    // Failed SC never touches the RAM and answers in the grant cycle.
                    dwait    = 1'b0;
                    w_d_done = 1'b1;
                    w_next   = IDLE;
                end else begin
                    ramREN   = dREN;
                    ramWEN   = dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (w_ram_done) begin
                        dwait        = 1'b0;
                        dload        = w_err ? ERRVAL : ((dWEN & datomic) ? 32'd1 : ramload);
                        w_d_done     = 1'b1;
                        w_d_ram_done = 1'b1;
                        w_next       = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_link_set = w_d_ram_done & ~w_err & dREN & datomic;
    assign w_link_clr = w_d_ram_done & ~w_err & dWEN & (datomic | w_hit);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= IDLE;
            r_dcount <= '0;
            r_memerr <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_i_done)
                r_dcount <= '0;
            else if (w_d_done)
                r_dcount <= !iREN ? '0 : ((r_dcount == DMAX) ? DMAX : r_dcount + 1'b1);
            if ((w_i_done | w_d_ram_done) & w_err)
                r_memerr <= 1'b1;
        end
    end

    llsc_link u_link (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_set   (w_link_set),
        .i_clr   (w_link_clr),
        .i_addr  (daddr),
        .o_hit   (w_hit),
        .o_match (w_match)
    );
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: transaction-level memory/link reference model,
// latency-randomised RAM responder, and a negedge monitor that pops expectations.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int    IMAX   = 4;
    localparam word_t ERRVAL = 32'hBAD1BAD1;
    localparam int OP_RD = 0, OP_WR = 1, OP_LL = 2, OP_SC = 3;

    logic      CLK, RST;
    logic      iREN, iwait, dREN, dWEN, datomic, dwait, ramREN, ramWEN, memerr;
    word_t     iaddr, iload, daddr, dstore, dload, ramaddr, ramstore, ramload;
    ramstate_t ramstate;

    mem_arbiter #(.IMAX(IMAX), .ERRVAL(ERRVAL)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .datomic(datomic), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct { logic chk; word_t exp; } dexp_t;
    word_t iq[$];
    dexp_t dq[$];
    int    compared = 0, mismatched = 0;

    word_t ram    [0:1023];
    word_t refmem [0:1023];
    logic  ref_lv;
    word_t ref_la;
    int    exp_wr;
    int    ren_cnt = 0, ilow_cnt = 0, wen_cnt = 0, cyc_now = 0, last_i_cyc = 0, last_d_cyc = 0;
    string order;
    int    c1, c2, ci, cd, w0;
    int    cnt = 0, rnd_lat = 1, forced_lat;
    logic  err_inject;

    function automatic word_t init_val(input int i);
        return 32'h1000_0000 + 32'(i) * 7;
    endfunction

    task automatic check(input string name, input word_t act, input word_t exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
        end
    endtask

    // RAM responder: BUSY for a per-access latency, then ACCESS (or ERROR when injected)
    always_comb begin
        if (!(ramREN || ramWEN))
            ramstate = FREE;
        else if (cnt >= ((forced_lat >= 0) ? forced_lat : rnd_lat))
            ramstate = err_inject ? ERROR : ACCESS;
        else
            ramstate = BUSY;
        ramload = ram[ramaddr[9:0]];
    end

    always @(posedge CLK) begin
        if (ramREN || ramWEN) begin
            if (ramstate == ACCESS || ramstate == ERROR) begin
                cnt     <= 0;
                rnd_lat <= int'($urandom_range(0, 2));
                if (ramWEN && ramstate == ACCESS) ram[ramaddr[9:0]] <= ramstore;
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    // Monitor: pops an expectation whenever a requester sees its wait drop
    always @(negedge CLK) begin
        if (!RST) begin
            cyc_now++;
            if (iREN && !iwait) begin
                order = {order, "I"};
                last_i_cyc = cyc_now;
                ilow_cnt++;
                if (iq.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL i_unexpected: got iload %h with no pending fetch", iload);
                end else check("iload", iload, iq.pop_front());
            end
            if ((dREN || dWEN) && !dwait) begin
                dexp_t e;
                order = {order, "D"};
                last_d_cyc = cyc_now;
                if (dq.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL d_unexpected: got dload %h with no pending access", dload);
                end else begin
                    e = dq.pop_front();
                    if (e.chk) check("dload", dload, e.exp);
                end
            end
            check("waits_exclusive", 32'(!iwait && !dwait), 0);
            check("strobes_exclusive", 32'(ramREN && ramWEN), 0);
            check("iwait_idle", 32'(!iREN && !iwait), 0);
            check("dwait_idle", 32'(!dREN && !dWEN && !dwait), 0);
            if (ramREN) ren_cnt++;
            if (ramWEN && ramstate == ACCESS) wen_cnt++;
        end
    end

    task automatic do_i(input word_t a, output int cyc);
        iq.push_back(err_inject ? ERRVAL : refmem[a[9:0]]);
        iaddr = a;
        iREN  = 1'b1;
        cyc   = 0;
        do begin @(negedge CLK); cyc++; end while (iwait && cyc < 200);
        if (iwait) begin
            compared++; mismatched++;
            $display("FAIL i_timeout: got no completion in %0d cycles required completion", cyc);
        end
        @(posedge CLK); #1;
        iREN = 1'b0;
    endtask

    task automatic do_d(input int op, input word_t a, input word_t d, output int cyc);
        dexp_t e;
        int idx = int'(a[9:0]);
        e.chk = 1'b1;
        e.exp = '0;
        case (op)
            OP_RD: e.exp = refmem[idx];
            OP_LL: begin e.exp = refmem[idx]; ref_lv = 1'b1; ref_la = a; end
            OP_WR: begin
                e.chk = 1'b0;
                refmem[idx] = d;
                exp_wr++;
                if (a == ref_la) ref_lv = 1'b0;
            end
            default: begin
                if (ref_lv && ref_la == a) begin
                    e.exp = 32'd1; refmem[idx] = d; exp_wr++; ref_lv = 1'b0;
                end
            end
        endcase
        dq.push_back(e);
        daddr   = a;
        dstore  = d;
        dREN    = (op == OP_RD || op == OP_LL);
        dWEN    = !dREN;
        datomic = (op == OP_LL || op == OP_SC);
        cyc     = 0;
        do begin @(negedge CLK); cyc++; end while (dwait && cyc < 200);
        if (dwait) begin
            compared++; mismatched++;
            $display("FAIL d_timeout: got no completion in %0d cycles required completion", cyc);
        end
        @(posedge CLK); #1;
        dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        err_inject = 1'b0; forced_lat = -1; ref_lv = 1'b0; ref_la = '0; exp_wr = 0; order = "";
        for (int i = 0; i < 1024; i++) begin ram[i] = init_val(i); refmem[i] = init_val(i); end
        #6;
        check("rst_ramREN", 32'(ramREN), 0);
        check("rst_ramWEN", 32'(ramWEN), 0);
        check("rst_iwait", 32'(iwait), 1);
        check("rst_dwait", 32'(dwait), 1);
        check("rst_dload", dload, 0);
        check("rst_memerr", 32'(memerr), 0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // Fetch alone, two BUSY cycles before ACCESS
        forced_lat = 2; ren_cnt = 0; ilow_cnt = 0;
        do_i(32'h40, c1);
        check("t1_ramREN_cycles", 32'(ren_cnt), 3);
        check("t1_iwait_low_cycles", 32'(ilow_cnt), 1);
        check("t1_latency", 32'(c1), 4);

        // Simultaneous fetch and data read: data first, one IDLE, then fetch
        forced_lat = 0; order = "";
        fork
            do_i(32'h41, c1);
            do_d(OP_RD, 32'h100, 32'h0, c2);
        join
        check_str("t2_order", order, "DI");
        check("t2_i_after_d_cycles", 32'(last_i_cyc - last_d_cyc), 2);

        // Starvation bound: IMAX data grants, then the fetch, then data again
        forced_lat = -1; order = "";
        fork
            do_i(32'h42, c1);
            for (int k = 0; k < 6; k++) do_d(OP_RD, 32'h100 + word_t'(k % 4), 32'h0, c2);
        join
        check_str("t3_order", order, "DDDDIDD");

        // LL then SC succeeds once; a repeated SC fails in the grant cycle
        do_d(OP_LL, 32'h200, 32'h0, c1);
        w0 = wen_cnt;
        do_d(OP_SC, 32'h200, 32'h55, c1);
        check("t4_sc_writes", 32'(wen_cnt - w0), 1);
        check("t4_ram_word", ram[512], 32'h55);
        w0 = wen_cnt;
        do_d(OP_SC, 32'h200, 32'h66, c1);
        check("t4_sc2_latency", 32'(c1), 2);
        check("t4_sc2_writes", 32'(wen_cnt - w0), 0);

        // A plain store to the linked word breaks the reservation
        do_d(OP_LL, 32'h200, 32'h0, c1);
        do_d(OP_WR, 32'h200, 32'h77, c1);
        w0 = wen_cnt;
        do_d(OP_SC, 32'h200, 32'h99, c1);
        check("t5_sc_latency", 32'(c1), 2);
        check("t5_sc_writes", 32'(wen_cnt - w0), 0);
        check("t5_ram_word", ram[512], 32'h77);

        // Reset in the middle of a BUSY fetch
        do_d(OP_LL, 32'h200, 32'h0, c1);
        forced_lat = 6;
        iaddr = 32'h43; iREN = 1'b1;
        repeat (3) @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check("t6_rst_ramREN", 32'(ramREN), 0);
        check("t6_rst_iwait", 32'(iwait), 1);
        iREN = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0; ref_lv = 1'b0; forced_lat = 0;
        do_i(32'h44, c1);
        check("t6_post_rst_latency", 32'(c1), 2);
        w0 = wen_cnt;
        do_d(OP_SC, 32'h200, 32'hAA, c1);
        check("t6_sc_after_rst_writes", 32'(wen_cnt - w0), 0);
        check("t6_memerr_clear", 32'(memerr), 0);

        // ERROR completion returns ERRVAL and latches memerr
        err_inject = 1'b1;
        do_i(32'h45, c1);
        err_inject = 1'b0;
        check("t6_memerr_set", 32'(memerr), 1);
        do_i(32'h46, c1);
        check("t6_memerr_sticky", 32'(memerr), 1);

        // Random concurrent traffic against the reference model
        forced_lat = -1;
        fork
            for (int k = 0; k < 40; k++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
                do_i(word_t'($urandom_range(0, 63)), ci);
            end
            for (int k = 0; k < 60; k++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
                do_d(int'($urandom_range(0, 3)), 32'h100 + word_t'($urandom_range(0, 3)),
                     word_t'($urandom), cd);
            end
        join

        check("total_ram_writes", 32'(wen_cnt), 32'(exp_wr));
        for (int a = 256; a < 260; a++) check("final_ram_word", ram[a], refmem[a]);
        check("final_ram_link_word", ram[512], refmem[512]);
        check("iq_drained", 32'(iq.size()), 0);
        check("dq_drained", 32'(dq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
